// File: rtl/mem_access_unit.sv
// Data-memory access stage: turns EX/MEM load/store controls into one outstanding
// dmem transaction and stalls the upstream pipeline until that transaction retires.
module mem_access_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] store_data_in,
    input  logic [4:0]  rd_addr_in,
    input  logic [2:0]  funct3_in,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic        RegWrite_in,
    input  logic        MemToReg_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] alu_result_out,
    output logic [31:0] mem_read_data_out,
    output logic [4:0]  rd_addr_out,
    output logic        RegWrite_out,
    output logic        MemToReg_out,
    output logic        stall_out,
    output logic        fault_out
);

    typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [4:0]  rd_q, rd_d;
    logic        store_q, store_d;
    logic        regwrite_q, regwrite_d;
    logic        memtoreg_q, memtoreg_d;
    logic [31:0] rdata_q, rdata_d;

    logic        mem_op;
    logic        legal;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;

    // Picks the addressed lane out of a returned word and sign/zero-extends it.
    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [1:0]  off,
                                                input logic [2:0]  f3);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(word >> {off, 3'b000});
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'b0, b};
            3'b101:  return {16'b0, h};
            default: return word;
        endcase
    endfunction

    // Access decode: legality, byte enables and lane-replicated store data.
    always_comb begin
        mem_op    = valid_in & (MemRead_in | MemWrite_in);
        legal     = 1'b0;
        be_new    = 4'b0000;
        wdata_new = store_data_in;
        case (funct3_in)
            3'b000: begin
                legal     = 1'b1;
                be_new    = 4'b0001 << alu_result_in[1:0];
                wdata_new = {4{store_data_in[7:0]}};
            end
            3'b001: begin
                legal     = ~alu_result_in[0];
                be_new    = alu_result_in[1] ? 4'b1100 : 4'b0011;
                wdata_new = {2{store_data_in[15:0]}};
            end
            3'b010: begin
                legal  = (alu_result_in[1:0] == 2'b00);
                be_new = 4'b1111;
            end
            3'b100:  legal = ~MemWrite_in;
            3'b101:  legal = ~MemWrite_in & ~alu_result_in[0];
            default: legal = 1'b0;
        endcase
        // Loads always fetch the whole word; the lane is selected on return.
        if (!MemWrite_in) begin
            be_new = 4'b1111;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        funct3_d   = funct3_q;
        rd_d       = rd_q;
        store_d    = store_q;
        regwrite_d = regwrite_q;
        memtoreg_d = memtoreg_q;
        rdata_d    = rdata_q;
        case (state_q)
            StIdle: begin
                if (mem_op && legal) begin
                    addr_d     = alu_result_in;
                    wdata_d    = wdata_new;
                    be_d       = be_new;
                    funct3_d   = funct3_in;
                    rd_d       = rd_addr_in;
                    store_d    = MemWrite_in;
                    regwrite_d = RegWrite_in;
                    memtoreg_d = MemToReg_in;
                    rdata_d    = '0;
                    state_d    = StReq;
                end
            end
            StReq: begin
                if (dmem_ack) begin
                    rdata_d = store_q ? '0 : load_extend(dmem_rdata, addr_q[1:0], funct3_q);
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            funct3_q   <= '0;
            rd_q       <= '0;
            store_q    <= 1'b0;
            regwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            funct3_q   <= funct3_d;
            rd_q       <= rd_d;
            store_q    <= store_d;
            regwrite_q <= regwrite_d;
            memtoreg_q <= memtoreg_d;
            rdata_q    <= rdata_d;
        end
    end

    always_comb begin
        dmem_req          = 1'b0;
        dmem_we           = 1'b0;
        dmem_be           = 4'b0000;
        dmem_addr         = {addr_q[31:2], 2'b00};
        dmem_wdata        = wdata_q;
        alu_result_out    = addr_q;
        mem_read_data_out = '0;
        rd_addr_out       = rd_q;
        RegWrite_out      = 1'b0;
        MemToReg_out      = memtoreg_q;
        stall_out         = 1'b0;
        fault_out         = 1'b0;
        case (state_q)
            StIdle: begin
                alu_result_out = alu_result_in;
                rd_addr_out    = rd_addr_in;
                RegWrite_out   = RegWrite_in;
                MemToReg_out   = MemToReg_in;
                // Gated by rst so an asserted reset drops stall/fault immediately.
                if (mem_op) begin
                    RegWrite_out = 1'b0;
                    stall_out    = rst & legal;
                    fault_out    = rst & ~legal;
                end
            end
            StReq: begin
                dmem_req  = 1'b1;
                dmem_we   = store_q;
                dmem_be   = be_q;
                stall_out = 1'b1;
            end
            StDone: begin
                mem_read_data_out = rdata_q;
                RegWrite_out      = regwrite_q;
            end
            default: ;
        endcase
    end

endmodule
